// File: rtl/alu_pipe.sv
// Registered ALU with NZCV flag register; single-cycle ops return a result the edge after accept, MUL after W steps.
// Backpressure: in_ready drops while a result is unconsumed or MUL is iterating; held results stay stable.
module alu_pipe #(
    parameter int W   = 8,
    parameter int SHW = $clog2(W) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         set_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         cout,
    output logic         overflow,
    output logic         negative,
    output logic         zero,
    output logic         illegal,
    output logic [3:0]   flags_q
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [3:0] OP_MUL = 4'b1011;

    logic [0:0]     state;
    logic [2*W-1:0] mcand, acc, mul_sum;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           mul_sf;

    logic [SHW-1:0]        amt;
    logic [2*W-1:0]        lsl_w, lsr_w;
    logic signed [2*W-1:0] asr_w;
    logic [W-1:0]          bop;
    logic                  cin_eff;
    logic [W:0]            sum;
    logic [W-1:0]          res_y;
    logic                  res_c, res_v, res_ill;

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign negative = y[W-1];
    assign zero     = (y == '0);
    assign mul_sum  = acc + (mplier[0] ? mcand : '0);

    // Shifts run in a 2W window so the bit just above/below the result is the carry-out.
    always_comb begin
        amt     = b[SHW-1:0];
        lsl_w   = {{W{1'b0}}, a} << amt;
        lsr_w   = {a, {W{1'b0}}} >> amt;
        asr_w   = $signed({a, {W{1'b0}}}) >>> amt;
        bop     = (opcode == 4'b1000 || opcode == 4'b1010) ? ~b : b;
        cin_eff = 1'b0;
        case (opcode)
            4'b0111: cin_eff = cin;
            4'b1000: cin_eff = 1'b1;
            4'b1001,
            4'b1010: cin_eff = flags_q[1];
            default: cin_eff = 1'b0;
        endcase
        sum     = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, cin_eff};
        res_y   = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_ill = 1'b0;
        case (opcode)
            4'b0000: begin res_y = lsl_w[W-1:0];     res_c = lsl_w[W];   end
            4'b0001: begin res_y = lsr_w[2*W-1:W];   res_c = lsr_w[W-1]; end
            4'b0010: begin res_y = asr_w[2*W-1:W];   res_c = asr_w[W-1]; end
            4'b0011: res_y = ~a;
            4'b0100: res_y = a & b;
            4'b0101: res_y = a | b;
            4'b0110: res_y = a ^ b;
            4'b0111, 4'b1000, 4'b1001, 4'b1010: begin
                res_y = sum[W-1:0];
                res_c = sum[W];
                res_v = (a[W-1] == bop[W-1]) && (sum[W-1] != a[W-1]);
            end
            4'b1011: res_y = '0;
            default: res_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
            mul_sf    <= 1'b0;
            out_valid <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (opcode == OP_MUL) begin
                            state  <= S_MUL;
                            mcand  <= {{W{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= '0;
                            mul_sf <= set_flags;
                        end else begin
                            y         <= res_y;
                            cout      <= res_c;
                            overflow  <= res_v;
                            illegal   <= res_ill;
                            out_valid <= 1'b1;
                            if (set_flags && !res_ill)
                                flags_q <= {res_y[W-1], res_y == '0, res_c, res_v};
                        end
                    end
                end
                default: begin
                    acc    <= mul_sum;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state     <= S_IDLE;
                        y         <= mul_sum[W-1:0];
                        cout      <= |mul_sum[2*W-1:W];
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        if (mul_sf)
                            flags_q <= {mul_sum[W-1], mul_sum[W-1:0] == '0, |mul_sum[2*W-1:W], 1'b0};
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (W=8): vector table plus hand-written MUL, carry-chain, stall and reset sequences.
module tb_alu_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] opcode = 4'h0;
    logic [7:0] a = 8'h00, b = 8'h00;
    logic       cin = 1'b0, set_flags = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] y;
    logic       cout, overflow, negative, zero, illegal;
    logic [3:0] flags_q;

    int checks = 0;
    int failures = 0;

    alu_pipe #(.W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .cin(cin), .set_flags(set_flags),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .cout(cout),
        .overflow(overflow), .negative(negative), .zero(zero),
        .illegal(illegal), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] va, vb;
        logic       vcin, vsf;
        logic [7:0] ey;
        logic       ec, ev, en, ez;
    } vec_t;

    vec_t vt[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one request at the falling edge; returns 1ns after the accepting rising edge.
    task automatic apply(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input logic vcin, input logic vsf);
        @(negedge clk);
        opcode = op; a = va; b = vb; cin = vcin; set_flags = vsf; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic saw_valid;

        vt[0]  = '{4'h0, 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{4'h2, 8'h90, 8'h01, 1'b0, 1'b0, 8'hC8, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2]  = '{4'h1, 8'h81, 8'h08, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3]  = '{4'h3, 8'h0F, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{4'h4, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{4'h5, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[6]  = '{4'h6, 8'hCC, 8'hAA, 1'b0, 1'b0, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{4'h7, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[8]  = '{4'h8, 8'h05, 8'h05, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{4'h0, 8'h81, 8'h08, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[10] = '{4'h2, 8'h80, 8'h09, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[11] = '{4'h0, 8'h81, 8'h00, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[12] = '{4'h7, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[13] = '{4'h8, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[14] = '{4'h8, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[15] = '{4'h1, 8'h81, 8'h01, 1'b0, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("por_out_valid", out_valid, 0);
        check("por_flags", flags_q, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_in_ready", in_ready, 1);

        for (int i = 0; i < 16; i++) begin
            apply(vt[i].op, vt[i].va, vt[i].vb, vt[i].vcin, vt[i].vsf);
            check($sformatf("v%0d_valid", i), out_valid, 1);
            check($sformatf("v%0d_y", i), y, vt[i].ey);
            check($sformatf("v%0d_c", i), cout, vt[i].ec);
            check($sformatf("v%0d_v", i), overflow, vt[i].ev);
            check($sformatf("v%0d_n", i), negative, vt[i].en);
            check($sformatf("v%0d_z", i), zero, vt[i].ez);
            check($sformatf("v%0d_ill", i), illegal, 0);
            if (vt[i].vsf)
                check($sformatf("v%0d_flags", i), flags_q, {vt[i].en, vt[i].ez, vt[i].ec, vt[i].ev});
        end

        // Carry chain: ADD sets C, ADC on the very next edge consumes it
        apply(4'h7, 8'hFF, 8'h01, 1'b0, 1'b1);
        check("chain_add_y", y, 8'h00);
        check("chain_add_flags", flags_q, 4'b0110);
        apply(4'h9, 8'h00, 8'h00, 1'b0, 1'b1);
        check("chain_adc_y", y, 8'h01);
        check("chain_adc_flags", flags_q, 4'b0000);
        apply(4'hA, 8'h05, 8'h03, 1'b0, 1'b0);
        check("sbc_c0_y", y, 8'h01);
        check("sbc_c0_c", cout, 1);
        check("sbc_flags_kept", flags_q, 4'b0000);

        // MUL 0x10*0x11 = 0x110: in_ready low through edges k..k+7, result at k+8
        apply(4'hB, 8'h10, 8'h11, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("mul_busy%0d_rdy", i), in_ready, 0);
            check($sformatf("mul_busy%0d_vld", i), out_valid, 0);
            @(posedge clk);
            #1;
        end
        check("mul_busy7_rdy", in_ready, 0);
        check("mul_busy7_vld", out_valid, 0);
        @(posedge clk);
        #1;
        check("mul_valid", out_valid, 1);
        check("mul_y", y, 8'h10);
        check("mul_c", cout, 1);
        check("mul_v", overflow, 0);
        check("mul_flags", flags_q, 4'b0010);

        apply(4'hB, 8'h0F, 8'h0D, 1'b0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        check("mul2_y", y, 8'hC3);
        check("mul2_c", cout, 0);
        check("mul2_n", negative, 1);

        // Reset three edges into a MUL aborts it
        apply(4'hB, 8'h03, 8'h05, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_y", y, 8'h00);
        check("abort_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_result", saw_valid, 0);
        check("abort_idle_ready", in_ready, 1);

        // Backpressure: XOR result held while a pending AND waits
        out_ready = 1'b0;
        apply(4'h6, 8'hCC, 8'hAA, 1'b0, 1'b0);
        @(negedge clk);
        opcode = 4'h4; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d_y", i), y, 8'h66);
            check($sformatf("stall%0d_vld", i), out_valid, 1);
            check($sformatf("stall%0d_rdy", i), in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("release_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("release_and_y", y, 8'h30);
        check("release_and_vld", out_valid, 1);

        // Illegal opcode leaves flags_q alone
        apply(4'h7, 8'h7F, 8'h01, 1'b0, 1'b1);
        check("pre_ill_flags", flags_q, 4'b1001);
        apply(4'hE, 8'hFF, 8'hFF, 1'b0, 1'b1);
        check("ill_flag", illegal, 1);
        check("ill_y", y, 8'h00);
        check("ill_cv", {cout, overflow}, 2'b00);
        check("ill_flags_q", flags_q, 4'b1001);
        apply(4'h5, 8'h01, 8'h02, 1'b0, 1'b0);
        check("post_ill_clear", illegal, 0);
        check("post_ill_y", y, 8'h03);

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_y", y, 8'h00);
        check("arst_flags", flags_q, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst_release_rdy", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
